bin2bcd_seq: RTL

Sequential double-dabble converter from unsigned binary to packed BCD. It sits directly upstream of the 7-segment display driver and feeds that driver's 16-bit `num` input, so CPU debug values (PC, register contents, cycle counts) show as decimal digits. Conversion is multi-cycle, one shift per clock, with a start/busy/done handshake. The output register updates only at completion, so the display never shows a partial result.

---
 rtl/bin2bcd_pkg.sv | 11 +
 rtl/bcd_add3.sv | 16 +
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants for the sequential binary to BCD converter
package bin2bcd_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam int         BCD_DIGIT_W    = 4;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit adjust: digits of 5 or more get 3 added before the shift
module bcd_add3
   import bin2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] d_o
);

   always_comb begin
      d_o = d_i;
      if (d_i >= BCD_ADJ_THRESH) begin
         d_o = d_i + BCD_ADJ_ADD;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter, one shift per clock
// Define BIN2BCD_CLAMP_EN to saturate out-of-range results to all 9s and expose ovf_o.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [IN_W-1:0]               bin_i,
   output logic                          busy_o,
   output logic                          done_o,
`ifdef BIN2BCD_CLAMP_EN
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
   output logic                          ovf_o
`else
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o
`endif
);

   // One spare scratch digit keeps out-of-range inputs exact until truncation or clamping.
   localparam int SCR_W = BCD_DIGIT_W * (DIGITS + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);

   logic [0:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IN_W-1:0]       bin_q, bin_d;
   logic [SCR_W-1:0]      scr_q, scr_d, scr_adj;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic                  done_q, done_d;
   logic [SCR_W+IN_W-1:0] shifted;
`ifdef BIN2BCD_CLAMP_EN
   logic                  ovf_q, ovf_d;
`endif

   for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .d_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .d_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      shifted = {scr_adj, bin_q} << 1;
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
`ifdef BIN2BCD_CLAMP_EN
      ovf_d   = ovf_q;
`endif
      if (state_q == ST_IDLE) begin
         if (start_i) begin
            bin_d   = bin_i;
            scr_d   = '0;
            cnt_d   = CNT_W'(IN_W);
            state_d = ST_SHIFT;
         end
      end else begin
         {scr_d, bin_d} = shifted;
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef BIN2BCD_CLAMP_EN
            if (scr_d[SCR_W-1 -: BCD_DIGIT_W] != '0) begin
               bcd_d = {DIGITS{4'h9}};
               ovf_d = 1'b1;
            end else begin
               bcd_d = scr_d[BCD_W-1:0];
               ovf_d = 1'b0;
            end
`else
            bcd_d = scr_d[BCD_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
`ifdef BIN2BCD_CLAMP_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
`ifdef BIN2BCD_CLAMP_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy_o = (state_q == ST_SHIFT);
   assign done_o = done_q;
   assign bcd_o  = bcd_q;
`ifdef BIN2BCD_CLAMP_EN
   assign ovf_o  = ovf_q;
`endif

endmodule
